// File: rtl/dpd_capture_buf.sv
// Captures 2^AW paired reference/feedback samples after a start edge plus loop delay,
// then serves them through a registered, latency-1 read port.
module dpd_capture_buf #(
   parameter int W  = 16,
   parameter int AW = 10,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_b,
   input  logic          start,
   input  logic [DW-1:0] delay,
   input  logic [W-1:0]  tx_i,
   input  logic [W-1:0]  tx_q,
   input  logic [W-1:0]  fb_i,
   input  logic [W-1:0]  fb_q,
   output logic          busy,
   output logic          done,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_valid,
   output logic [W-1:0]  rd_tx_i,
   output logic [W-1:0]  rd_tx_q,
   output logic [W-1:0]  rd_fb_i,
   output logic [W-1:0]  rd_fb_q
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAPT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t          state_q;
   logic            s0_q, s1_q, trig_q;
   logic            trig_d;
   logic [DW:0]     cnt_q;
   logic [AW-1:0]   wr_addr_q;
   logic            busy_q, done_q;
   logic            wr_en;
   logic            rd_acc;
   logic            rd_valid_q;
   logic [4*W-1:0]  rd_dat_q;
   logic [4*W-1:0]  mem_q [2**AW];

   // Same two-flop edge detector as the generator, so trig lines up with its start pulse.
   assign trig_d = s0_q & ~s1_q;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         s0_q   <= 1'b0;
         s1_q   <= 1'b0;
         trig_q <= 1'b0;
      end else begin
         s0_q   <= start;
         s1_q   <= s0_q;
         trig_q <= trig_d;
      end
   end

   // The trig cycle counts as the first of delay+2 wait cycles, hence the load of delay+1.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wr_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else if (trig_q) begin
         state_q   <= ST_WAIT;
         cnt_q     <= {1'b0, delay} + (DW+1)'(1);
         wr_addr_q <= '0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_WAIT: begin
               if (cnt_q == (DW+1)'(1)) begin
                  state_q <= ST_CAPT;
               end else begin
                  cnt_q <= cnt_q - (DW+1)'(1);
               end
            end
            ST_CAPT: begin
               wr_addr_q <= wr_addr_q + AW'(1);
               if (wr_addr_q == {AW{1'b1}}) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign wr_en  = (state_q == ST_CAPT);
   assign rd_acc = rd_en & done_q & ~trig_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr_q] <= {tx_i, tx_q, fb_i, fb_q};
      end
   end

   // Rejected reads leave the data register untouched.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rd_valid_q <= 1'b0;
         rd_dat_q   <= '0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) begin
            rd_dat_q <= mem_q[rd_addr];
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_valid = rd_valid_q;
   assign rd_tx_i  = rd_dat_q[4*W-1:3*W];
   assign rd_tx_q  = rd_dat_q[3*W-1:2*W];
   assign rd_fb_i  = rd_dat_q[2*W-1:W];
   assign rd_fb_q  = rd_dat_q[W-1:0];

endmodule

// File: doc/dpd_capture_buf.md
Name: dpd_capture_buf

Overview:
- Downstream companion of the DPD training-signal playback generator.
- On the same `start` rising edge that launches playback, captures 2^AW consecutive samples into two RAM banks:
  - the transmitted reference (tx_i/tx_q, from the generator),
  - the PA feedback (fb_i/fb_q, from the observation ADC path).
- Capture is offset by a programmable loop delay.
- Captured pairs are read back through a registered read port by the coefficient-estimation logic.

Parameters:
- W, 16, sample width of each I/Q component (two's complement, stored unmodified).
- AW, 10, capture address width; depth N = 2^AW entries per bank.
- DW, 8, width of the loop-delay input.

Ports:
- clk  in  1  clock.
- reset_b  in  1  reset, asynchronous, active-low.
- start  in  1  level from control, same signal driven to the generator; its rising edge triggers capture.
- delay  in  DW  loop delay in clk cycles; sampled on the trigger cycle only.
- tx_i  in  W  reference I from generator.
- tx_q  in  W  reference Q from generator.
- fb_i  in  W  feedback I from observation path.
- fb_q  in  W  feedback Q from observation path.
- busy  out  1  high while waiting or capturing.
- done  out  1  high when a complete capture is stored; held until next trigger.
- rd_en  in  1  read request.
- rd_addr  in  AW  read address.
- rd_valid  out  1  read data valid.
- rd_tx_i  out  W  read reference I.
- rd_tx_q  out  W  read reference Q.
- rd_fb_i  out  W  read feedback I.
- rd_fb_q  out  W  read feedback Q.

Behaviour:
- Reset values: busy=0, done=0, rd_valid=0, all rd_* data=0, state=IDLE. RAM contents are not reset.

Trigger:
- start passes through two flops, s0 then s1.
- trig is registered as s0 & ~s1. This is identical to the generator, so trig is high in the same cycle T as the generator's internal start pulse.
- The generator presents its sample 0 on tx_i/tx_q during cycle T+2, and sample k during T+2+k.

Alignment:
- Entry k (k = 0..N-1) of both banks samples tx_*/fb_* at the rising edge ending cycle T+2+delay+k.
- delay=0 therefore stores generator sample k at address k.
- With delay=D, the tx bank holds generator samples shifted by D. The block does not compensate this; the shift is intended so that the fb bank lines up with the PA response.

State machine:
- IDLE: waits for trig.
- WAIT: loaded on trig; counts delay+2 cycles, then moves to CAPT.
- CAPT: writes both banks at wr_addr 0..N-1, one per cycle, no gaps. After the write at N-1, moves to DONE.
- DONE: done=1.
- busy=1 exactly in WAIT and CAPT.
- On the trig cycle: done drops to 0 the following cycle and busy rises the following cycle.

Simultaneous events and restart:
- trig in any state (including WAIT or CAPT) restarts: re-sample delay, wr_addr=0, enter WAIT. Entries from the aborted capture are overwritten progressively.
- trig on the same cycle as the final CAPT write: the restart wins and done never asserts.
- start held high produces no further triggers; only a new low-to-high edge retriggers.

Write addressing:
- wr_addr is AW bits with no wrap.
- Capture ends after exactly N writes, so the generator's 1024-sample play length matches AW=10.

Read port:
- rd_en is accepted only when done=1 and the trigger is not active.
- Accepted read: rd_valid=1 and data = entry rd_addr on the next cycle (latency 1). Back-to-back reads give one result per cycle.
- rd_en while done=0: ignored, rd_valid=0, rd data holds its previous value.
- rd_valid is a single-cycle indication per accepted request.
- Read and write never overlap, so a single-port RAM per bank (or one 4W-wide bank) is sufficient.

Widths:
- No arithmetic on data.
- The delay counter is DW+1 bits so that delay+2 cannot overflow.

Test Plan:
1. Reset, then rd_en=1 at rd_addr=5 → rd_valid stays 0; busy=0, done=0.
2. Drive tx = generator model (sample k = k), fb = tx delayed by 7 cycles; delay=7; raise start → busy asserts 3 cycles after the start edge; done asserts after 2+7+1024 cycles; read addr 0..1023 → fb entry k = k and tx entry k = k+7 (the tx bank carries the 7-sample offset).
3. delay=0, fb=tx → every address returns tx==fb==k; rd_valid is exactly one cycle after each rd_en, including 1024 back-to-back reads.
4. Raise start again mid-CAPT (at wr_addr 300) → done never asserts for the first capture; done asserts after 2+delay+1024 cycles from the new trigger; all entries reflect the second run.
5. Hold start high for 5000 cycles → exactly one capture; done stays 1 until start goes low then high again.
6. Assert reset_b low mid-WAIT → busy and done go 0 immediately; after release, no capture starts until a fresh start edge.
